// File: rtl/labs_energy_serial.sv
// labs_energy_serial: serial LABS autocorrelation energy evaluator, one lag per cycle
// with a saturating accumulator and valid/ready handshakes on both sides.
module labs_energy_serial #(
  parameter int SEQ_WIDTH = 8,
  parameter int E_WIDTH   = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic [SEQ_WIDTH-1:0] i_seq,
  input  logic                 i_seq_valid,
  output logic                 o_seq_ready,
  output logic [E_WIDTH-1:0]   o_e,
  output logic                 o_e_valid,
  input  logic                 i_e_ready
);
  localparam int KW  = $clog2(SEQ_WIDTH);
  localparam int CW  = $clog2(SEQ_WIDTH) + 2;
  localparam int SQW = 2 * ($clog2(SEQ_WIDTH) + 1);
  localparam int SW  = ((E_WIDTH + 1 > SQW) ? E_WIDTH + 1 : SQW) + 1;
  localparam logic [E_WIDTH:0] E_MAX = {1'b0, {E_WIDTH{1'b1}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t                 r_state, w_next;
  logic                   r_live;
  logic [KW-1:0]          r_k;
  logic [E_WIDTH:0]       r_acc;
  logic [SEQ_WIDTH-1:0]   r_seq;
  logic [SEQ_WIDTH-1:0]   w_diff;
  logic [KW:0]            w_mism;
  logic signed [CW-1:0]   w_c;
  logic [SQW-1:0]         w_mag;
  logic [SQW-1:0]         w_sq;
  logic [SW-1:0]          w_sum;
  logic [E_WIDTH:0]       w_acc_n;
  logic                   w_last;
  // Only the N-k overlapping positions of the shifted sequence take part in lag k.
  assign w_diff = (r_seq ^ (r_seq >> r_k)) & ({SEQ_WIDTH{1'b1}} >> r_k);
  always_comb begin
    w_mism = '0;
    for (int i = 0; i < SEQ_WIDTH; i++) w_mism = w_mism + (KW + 1)'(w_diff[i]);
  end
  assign w_c     = CW'(SEQ_WIDTH) - CW'(r_k) - CW'({w_mism, 1'b0});
  assign w_mag   = w_c[CW-1] ? SQW'(-w_c) : SQW'(w_c);
  assign w_sq    = w_mag * w_mag;
  assign w_sum   = SW'(r_acc) + SW'(w_sq);
  assign w_acc_n = (w_sum > SW'(E_MAX)) ? E_MAX : w_sum[E_WIDTH:0];
  assign w_last  = r_k == KW'(SEQ_WIDTH - 1);
  // r_live keeps the input side closed while reset is held.
  assign o_seq_ready = (r_state == IDLE) && r_live;
  assign o_e_valid   = r_state == DONE;
  assign o_e         = r_acc[E_WIDTH-1:0];
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && r_live && i_seq_valid) w_next = CALC;
    else if (r_state == CALC && w_last) w_next = DONE;
    else if (r_state == DONE && i_e_ready) w_next = IDLE;
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_state <= IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_k   <= '0;
      r_acc <= '0;
      r_seq <= '0;
    end else if (o_seq_ready && i_seq_valid) begin
      r_seq <= i_seq;
      r_k   <= KW'(1);
      r_acc <= '0;
    end else if (r_state == CALC) begin
      r_acc <= w_acc_n;
      r_k   <= r_k + 1'b1;
    end
  end
endmodule

// File: tb/tb_labs_energy_serial.sv
// tb_labs_energy_serial: scoreboard bench for the serial LABS energy evaluator,
// with a second instance at E_WIDTH=7 for saturation.
module tb_labs_energy_serial;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [7:0]  seq = '0;
  logic        sv = 1'b0, sr, ev, er = 1'b1;
  logic [15:0] e;
  logic [7:0]  s_seq = 8'hFF;
  logic        s_sv = 1'b1, s_sr, s_ev, s_er = 1'b0;
  logic [6:0]  s_e;
  labs_energy_serial #(.SEQ_WIDTH(8), .E_WIDTH(16)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .i_seq(seq), .i_seq_valid(sv), .o_seq_ready(sr),
    .o_e(e), .o_e_valid(ev), .i_e_ready(er));
  labs_energy_serial #(.SEQ_WIDTH(8), .E_WIDTH(7)) dut_sat (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .i_seq(s_seq), .i_seq_valid(s_sv), .o_seq_ready(s_sr),
    .o_e(s_e), .o_e_valid(s_ev), .i_e_ready(s_er));
  int n_cmp = 0, n_err = 0, cyc = 0, rx = 0;
  int q[$];
  bit last_acc = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // Reference in the +1/-1 domain, saturated to the result width.
  function automatic int energy(input logic [7:0] s, input int ew);
    int en, c, mx;
    en = 0;
    for (int k = 1; k < 8; k++) begin
      c = 0;
      for (int i = 0; i < 8 - k; i++) c += (s[i] == s[i+k]) ? 1 : -1;
      en += c * c;
    end
    mx = (1 << ew) - 1;
    return (en > mx) ? mx : en;
  endfunction
  task automatic tick();
    bit a, o;
    int v, exp;
    logic [7:0] s;
    a = sv & sr & rst_n;
    o = ev & er & rst_n;
    v = int'(e);
    s = seq;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) q.delete();
    last_acc = a;
    if (a) q.push_back(energy(s, 16));
    if (o) begin
      rx++;
      exp = (q.size() > 0) ? q.pop_front() : -1;
      chk("scoreboard", v, exp);
    end
  endtask
  task automatic send(input logic [7:0] s);
    int t;
    seq = s;
    sv = 1'b1;
    t = 0;
    do begin
      tick();
      t++;
    end while (!last_acc && t < 100);
    chk("accept_seen", last_acc, 1);
    sv = 1'b0;
  endtask
  task automatic wait_ev(output int n);
    n = 0;
    while (!ev && n < 100) begin
      tick();
      n++;
    end
    chk("valid_seen", ev, 1);
  endtask
  initial begin
    int n, sent, rx0, last, min_gap, t;
    repeat (3) tick();
    chk("rst_ready", sr, 0);
    chk("rst_valid", ev, 0);
    chk("rst_e", e, 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", sr, 1);
    send(8'h00);
    wait_ev(n);
    chk("latency", n, 7);
    chk("e_zeros", e, 140);
    tick();
    er = 1'b0;
    send(8'h55);
    wait_ev(n);
    chk("e_alt", e, 140);
    er = 1'b1;
    tick();
    er = 1'b0;
    send(8'h0F);
    wait_ev(n);
    chk("e_0f", e, 60);
    repeat (20) begin
      tick();
      chk("bp_e", e, 60);
      chk("bp_ready", sr, 0);
      chk("bp_valid", ev, 1);
    end
    er = 1'b1;
    tick();
    chk("valid_drop", ev, 0);
    chk("ready_back", sr, 1);
    chk("sat_valid", s_ev, 1);
    chk("sat_e", s_e, 127);
    chk("sat_model", s_e, energy(8'hFF, 7));
    send(8'h0F);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (12) begin
      tick();
      chk("no_pulse", ev, 0);
    end
    chk("e_after_rst", e, 0);
    send(8'h00);
    wait_ev(n);
    chk("e_post_rst", e, 140);
    tick();
    sent = 0;
    rx0 = rx;
    last = -1;
    min_gap = 1000;
    t = 0;
    while ((rx - rx0) < 100 && t < 20000) begin
      if (!sv && sent < 100 && $urandom_range(0, 1) == 1) begin
        seq = 8'($urandom);
        sv = 1'b1;
      end
      er = $urandom_range(0, 3) != 0;
      tick();
      t++;
      if (last_acc) begin
        sv = 1'b0;
        sent++;
        if (last >= 0 && cyc - last < min_gap) min_gap = cyc - last;
        last = cyc;
      end
    end
    er = 1'b1;
    chk("stream_count", rx - rx0, 100);
    chk("stream_q_empty", q.size(), 0);
    chk("min_period", min_gap, 9);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
